memory_unit: RTL
================

Name: memory_unit

Overview:
- Sits directly downstream of the core datapath's memory port and adapts it to a Wishbone-style system bus.
- Takes byte/half/word(/double) load and store requests at arbitrary byte addresses. Generates aligned bus cycles with byte selects. Returns lane-shifted, sign/zero-extended load data.
- Flags misaligned accesses and bus timeouts back to the control unit.

Parameters:
- DATA_SIZE, 32, datapath and bus width (32 or 64).
- TIMEOUT_CYCLES, 255, maximum wait-for-ack cycles before access fault (1..255, 8-bit counter).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- rd_en  input  1  load request from control unit.
- wr_en  input  1  store request from control unit.
- size  input  2  access size, funct3[1:0]: 00 byte, 01 half, 10 word, 11 double.
- is_unsigned  input  1  funct3[2]; zero-extend loads when 1.
- addr  input  DATA_SIZE  byte address (mem_addr from datapath).
- wr_data  input  DATA_SIZE  store data, right-aligned (rs2).
- rd_data  output  DATA_SIZE  extended load result.
- busy  output  1  transaction in progress.
- done  output  1  one-cycle completion pulse.
- misaligned  output  1  valid with done; misaligned/illegal-size access.
- access_fault  output  1  valid with done; bus timeout.
- wb_cyc  output  1  bus cycle.
- wb_stb  output  1  bus strobe.
- wb_we  output  1  bus write enable.
- wb_sel  output  DATA_SIZE/8  byte lane selects.
- wb_adr  output  DATA_SIZE  bus address, aligned to DATA_SIZE/8 (low log2(DATA_SIZE/8) bits zero).
- wb_dat_o  output  DATA_SIZE  bus write data.
- wb_dat_i  input  DATA_SIZE  bus read data.
- wb_ack  input  1  bus acknowledge.

Behaviour:
- Reset (asynchronous):
  - Forces state IDLE.
  - Every output is 0: rd_data, busy, done, misaligned, access_fault, wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_o.
  - Wait counter is cleared.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - A request (rd_en | wr_en) is accepted on the clock edge; wr_en has priority if both are asserted.
  - addr, size, is_unsigned and wr_data are registered at acceptance; the core may drop its inputs afterwards.
- Alignment check at acceptance:
  - half requires addr[0]=0.
  - word requires addr[1:0]=0.
  - double requires addr[2:0]=0.
  - size=11 with DATA_SIZE=32 is illegal.
  - On failure: no bus cycle; go to RESP with misaligned=1.
- Aligned request: go to BUS.
  - wb_cyc=wb_stb=1 from the cycle after acceptance; wb_we = write.
  - wb_sel = size mask (1, 3, F, FF) shifted left by offset = addr[log2(DATA_SIZE/8)-1:0].
  - wb_dat_o = wr_data shifted left by 8*offset.
- BUS:
  - Wait counter increments each cycle without ack.
  - wb_ack=1 → capture wb_dat_i and go to RESP. wb_cyc/wb_stb deassert on the following edge (single-cycle ack, classic Wishbone).
  - Counter reaches TIMEOUT_CYCLES without ack → deassert wb_cyc/wb_stb and go to RESP with access_fault=1.
  - An ack arriving on the same cycle as the timeout wins; no fault is raised.
- RESP:
  - done=1 for exactly one cycle, then return to IDLE.
  - For loads, rd_data = (captured data >> 8*offset), truncated to size, then sign-extended (is_unsigned=0) or zero-extended.
  - rd_data holds its value until the next load completes.
  - Stores leave rd_data unchanged.
  - misaligned and access_fault are 1 only during done; otherwise 0.
  - rd_data is not updated on a faulted or misaligned load.
- busy: 1 in BUS and RESP; 0 in IDLE.
- Requests presented while not in IDLE are ignored. The control unit holds its request until done; a request held across done is re-accepted only in IDLE (minimum 3 cycles per access).
- Latency, aligned access with zero wait states: accept at edge N, cyc/stb high during cycle N+1, ack in cycle N+1, done high in cycle N+2.
- wb_ack while not in BUS is ignored.
- Counter and fault flags are cleared on each acceptance.

Test Plan:
- Aligned word load, DATA_SIZE=32, addr=0x1000, ack after 2 wait cycles, wb_dat_i=0xDEADBEEF → wb_adr=0x1000, wb_sel=1111, wb_we=0, cyc/stb high 3 cycles, done one cycle later, rd_data=0xDEADBEEF, misaligned=access_fault=0.
- Signed byte load, addr=0x2003, wb_dat_i=0x80123456 → wb_adr=0x2000, wb_sel=1000, rd_data=0xFFFFFF80. Repeat with is_unsigned=1 → rd_data=0x00000080.
- Halfword store, addr=0x3002, wr_data=0x0000ABCD → wb_we=1, wb_sel=1100, wb_dat_o[31:16]=0xABCD, done after ack, rd_data unchanged.
- Misaligned: word load at addr=0x4001, then size=11 at DATA_SIZE=32 → no wb_cyc ever asserted, done=1 and misaligned=1 one cycle after acceptance.
- Timeout: TIMEOUT_CYCLES=4, load with wb_ack held 0 → cyc/stb drop after 4 cycles, done=1 with access_fault=1, busy returns to 0. Late wb_ack afterwards is ignored.
- Reset mid-transaction: assert reset asynchronously during BUS → wb_cyc, wb_stb, busy drop immediately without a clock edge. After release, a new byte load completes normally.

Source files
------------

// File: rtl/memory_unit.sv
// Load/store adapter between the core memory port and a classic Wishbone bus.
// Aligns requests onto bus lanes, extends load data, and reports misalignment and bus timeouts.
module memory_unit #(
  parameter int DATA_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [1:0]             size,
  input  logic                   is_unsigned,
  input  logic [DATA_SIZE-1:0]   addr,
  input  logic [DATA_SIZE-1:0]   wr_data,
  output logic [DATA_SIZE-1:0]   rd_data,
  output logic                   busy,
  output logic                   done,
  output logic                   misaligned,
  output logic                   access_fault,
  output logic                   wb_cyc,
  output logic                   wb_stb,
  output logic                   wb_we,
  output logic [DATA_SIZE/8-1:0] wb_sel,
  output logic [DATA_SIZE-1:0]   wb_adr,
  output logic [DATA_SIZE-1:0]   wb_dat_o,
  input  logic [DATA_SIZE-1:0]   wb_dat_i,
  input  logic                   wb_ack
);

  localparam int NB    = DATA_SIZE / 8;
  localparam int OFF_W = $clog2(NB);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       fault_q, fault_d;
  logic       mis_q, mis_d;

  logic                 we_q;
  logic [1:0]           size_q;
  logic                 uns_q;
  logic [OFF_W-1:0]     off_q;
  logic [DATA_SIZE-1:0] adr_q, dat_q, rd_q;
  logic [NB-1:0]        sel_q;

  logic                 accept;
  logic [OFF_W-1:0]     req_off;
  logic                 req_mis;
  logic [7:0]           req_mask;
  logic [NB-1:0]        req_sel;
  logic [DATA_SIZE-1:0] lane_data, load_ext;
  logic                 ext_bit;
  int                   width;

  assign accept  = (state_q == IDLE) && (rd_en || wr_en);
  assign req_off = addr[OFF_W-1:0];

  // Alignment check and lane mask for the incoming request.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    req_mis  = 1'b0;
    req_mask = 8'h01;
    unique case (size)
      2'b00: req_mask = 8'h01;
      2'b01: begin
        req_mask = 8'h03;
        req_mis  = addr[0];
      end
      2'b10: begin
        req_mask = 8'h0F;
        req_mis  = (addr[1:0] != 2'b00);
      end
      default: begin
        req_mask = 8'hFF;
        req_mis  = (DATA_SIZE == 32) || (addr[2:0] != 3'b000);
      end
    endcase
    req_sel = NB'({8'h00, req_mask} << req_off);
  end

  // Shift the addressed lanes down, then sign- or zero-extend above the access width.
  always_comb begin
    lane_data = wb_dat_i >> {off_q, 3'b000};
    unique case (size_q)
      2'b00:   width = 8;
      2'b01:   width = 16;
      2'b10:   width = 32;
      default: width = 64;
    endcase
    if (width > DATA_SIZE) width = DATA_SIZE;
    ext_bit = ~uns_q & lane_data[width-1];
    load_ext = '0;
    for (int i = 0; i < DATA_SIZE; i++) begin
      load_ext[i] = (i < width) ? lane_data[i] : ext_bit;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= IDLE;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      mis_q   <= mis_d;
    end
  end

  // Ack is tested before the timeout, so an ack on the last wait cycle wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    mis_d   = mis_q;
    unique case (state_q)
      IDLE: if (rd_en || wr_en) begin
        cnt_d   = '0;
        fault_d = 1'b0;
        mis_d   = req_mis;
        state_d = req_mis ? RESP : BUS;
      end
      BUS: begin
        if (wb_ack) begin
          state_d = RESP;
        end else if (cnt_q == TIMEOUT_LAST) begin
          fault_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      we_q   <= 1'b0;
      size_q <= '0;
      uns_q  <= 1'b0;
      off_q  <= '0;
      adr_q  <= '0;
      sel_q  <= '0;
      dat_q  <= '0;
      rd_q   <= '0;
    end else if (accept) begin
      we_q   <= wr_en;
      size_q <= size;
      uns_q  <= is_unsigned;
      off_q  <= req_off;
      adr_q  <= {addr[DATA_SIZE-1:OFF_W], {OFF_W{1'b0}}};
      sel_q  <= req_sel;
      dat_q  <= wr_data << {req_off, 3'b000};
    end else if (state_q == BUS && wb_ack && !we_q) begin
      rd_q <= load_ext;
    end
  end

  always_comb begin
    wb_cyc       = (state_q == BUS);
    wb_stb       = wb_cyc;
    wb_we        = wb_cyc & we_q;
    wb_sel       = wb_cyc ? sel_q : '0;
    wb_adr       = wb_cyc ? adr_q : '0;
    wb_dat_o     = wb_cyc ? dat_q : '0;
    busy         = (state_q != IDLE);
    done         = (state_q == RESP);
    misaligned   = done & mis_q;
    access_fault = done & fault_q;
    rd_data      = rd_q;
  end

endmodule
